// File: rtl/csr_access_unit_if.sv
// Request, response and CSR-bus signals of the CSR access unit.
// The slave modport is the unit's own view; master is the view of the surrounding logic.
`timescale 1ns/1ps

interface csr_access_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [11:0]     req_addr;
  logic [XLEN-1:0] req_operand;
  logic            req_nowrite;
  logic            kill;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_illegal;

  logic            csr_en;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_set;
  logic [XLEN-1:0] csr_clear;
  logic            csr_ack;
  logic [XLEN-1:0] csr_rdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_operand, req_nowrite, kill,
    input  rsp_ready, csr_ack, csr_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_illegal,
    output csr_en, csr_addr, csr_set, csr_clear
  );

  modport master (
    output req_valid, req_op, req_addr, req_operand, req_nowrite, kill,
    output rsp_ready, csr_ack, csr_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_illegal,
    input  csr_en, csr_addr, csr_set, csr_clear
  );
endinterface

// File: rtl/csr_access_unit.sv
// CSR bus initiator: runs CSRRW/CSRRS/CSRRC as one set/clear bus access and returns the
// pre-write CSR value, or flags the instruction illegal.
`timescale 1ns/1ps

module csr_access_unit #(
  parameter int unsigned XLEN     = 32,
  parameter bit          RO_CHECK = 1'b1
) (
  input logic              clk_i,
  input logic              rst_i,
  csr_access_unit_if.slave bus
);

  localparam logic [1:0] OpRw = 2'b01;
  localparam logic [1:0] OpRs = 2'b10;
  localparam logic [1:0] OpRc = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [11:0]     addr_q, addr_d;
  logic [XLEN-1:0] operand_q, operand_d;
  logic            nowrite_q, nowrite_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            illegal_q, illegal_d;

  logic accept;
  logic req_is_write;
  logic req_reject;
  logic access_en;
  logic rsp_valid;

  // Request decode on the raw inputs, so a rejected request never reaches ACCESS.
  always_comb begin
    bus.req_ready = ~bus.kill &
                    ((state_q == StIdle) | ((state_q == StResp) & bus.rsp_ready));
    accept        = bus.req_valid & bus.req_ready;
    req_is_write  = (bus.req_op == OpRw) |
                    (((bus.req_op == OpRs) | (bus.req_op == OpRc)) & ~bus.req_nowrite);
    req_reject    = (bus.req_op == 2'b00) |
                    (RO_CHECK & (bus.req_addr[11:10] == 2'b11) & req_is_write);
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    operand_d = operand_q;
    nowrite_d = nowrite_q;
    data_d    = data_q;
    illegal_d = illegal_q;

    unique case (state_q)
      StIdle: ;
      StAccess: begin
        if (bus.kill) begin
          state_d = StIdle;
        end else begin
          state_d   = StResp;
          data_d    = bus.csr_ack ? bus.csr_rdata : '0;
          illegal_d = ~bus.csr_ack;
        end
      end
      StResp: begin
        if (bus.kill || bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // accept can only fire from IDLE or a consumed RESP, and never under kill.
    if (accept) begin
      op_d      = bus.req_op;
      addr_d    = bus.req_addr;
      operand_d = bus.req_operand;
      nowrite_d = bus.req_nowrite;
      if (req_reject) begin
        state_d   = StResp;
        data_d    = '0;
        illegal_d = 1'b1;
      end else begin
        state_d = StAccess;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      op_q      <= 2'b00;
      addr_q    <= 12'h000;
      operand_q <= '0;
      nowrite_q <= 1'b0;
      data_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      operand_q <= operand_d;
      nowrite_q <= nowrite_d;
      data_q    <= data_d;
      illegal_q <= illegal_d;
    end
  end

  // Bus drive: kill masks the enable combinationally so a flushed access never writes.
  always_comb begin
    access_en     = (state_q == StAccess) & ~bus.kill;
    bus.csr_en    = access_en;
    bus.csr_addr  = access_en ? addr_q : 12'h000;
    bus.csr_set   = '0;
    bus.csr_clear = '0;
    if (access_en) begin
      unique case (op_q)
        OpRw: begin
          bus.csr_set   = operand_q;
          bus.csr_clear = ~operand_q;
        end
        OpRs: bus.csr_set   = nowrite_q ? '0 : operand_q;
        OpRc: bus.csr_clear = nowrite_q ? '0 : operand_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    rsp_valid       = (state_q == StResp) & ~bus.kill;
    bus.rsp_valid   = rsp_valid;
    bus.rsp_data    = rsp_valid ? data_q : '0;
    bus.rsp_illegal = rsp_valid & illegal_q;
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: a small CSR fabric answers the bus, and a value-level model of the
// CSR file predicts every response and the final register contents.
`timescale 1ns/1ps

module tb_csr_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csr_access_unit_if #(.XLEN(32)) bus ();

  csr_access_unit #(.XLEN(32), .RO_CHECK(1'b1)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Fabric: four implemented CSRs; unknown addresses drive garbage read data and no ack.
  logic [31:0] fab_mem [4];
  logic [31:0] model_mem [4];
  logic        load_en = 1'b0;
  logic [1:0]  load_idx = 2'd0;
  logic [31:0] load_val = 32'h0;
  int          fab_idx;
  int          en_count = 0;
  int          cyc = 0;
  int          last_en_cyc = 0;
  int          prev_en_cyc = 0;

  function automatic int addr_idx(input logic [11:0] a);
    case (a)
      12'h340: return 0;
      12'h341: return 1;
      12'h305: return 2;
      12'hC00: return 3;
      default: return -1;
    endcase
  endfunction

  always_comb begin
    fab_idx       = addr_idx(bus.csr_addr);
    bus.csr_ack   = bus.csr_en && (fab_idx >= 0);
    bus.csr_rdata = (fab_idx >= 0) ? fab_mem[fab_idx[1:0]] : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (load_en) fab_mem[load_idx] <= load_val;
    else if (bus.csr_ack)
      fab_mem[fab_idx[1:0]] <= (fab_mem[fab_idx[1:0]] & ~bus.csr_clear) | bus.csr_set;
    if (bus.csr_en) begin
      en_count    <= en_count + 1;
      prev_en_cyc <= last_en_cyc;
      last_en_cyc <= cyc;
    end
    cyc <= cyc + 1;
  end

  // Reference: CSR instruction semantics on whole register values.
  function automatic void model_req(input logic [1:0] op, input logic [11:0] a,
                                    input logic [31:0] opd, input logic nw, input bit commit,
                                    output logic [31:0] e_data, output logic e_ill,
                                    output logic e_en, output logic [31:0] e_set,
                                    output logic [31:0] e_clr);
    bit wr;
    int idx;
    logic [31:0] old;
    wr     = (op == 2'b01) || (op != 2'b00 && !nw);
    e_data = 32'h0; e_ill = 1'b1; e_en = 1'b0; e_set = 32'h0; e_clr = 32'h0;
    if (op == 2'b00 || (a >= 12'hC00 && wr)) return;
    e_en = 1'b1;
    if (wr) begin
      case (op)
        2'b01: begin e_set = opd; e_clr = ~opd; end
        2'b10: e_set = opd;
        default: e_clr = opd;
      endcase
    end
    idx = addr_idx(a);
    if (idx < 0) return;
    old    = model_mem[idx[1:0]];
    e_ill  = 1'b0;
    e_data = old;
    if (commit && wr) begin
      if (op == 2'b01)      model_mem[idx[1:0]] = opd;
      else if (op == 2'b10) model_mem[idx[1:0]] = old | opd;
      else                  model_mem[idx[1:0]] = old & ~opd;
    end
  endfunction

  task automatic preload(input logic [1:0] idx, input logic [31:0] val);
    load_idx = idx; load_val = val; load_en = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0;
    model_mem[idx] = val;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [11:0] a, input logic [31:0] opd,
                           input logic nw);
    bus.req_op = op; bus.req_addr = a; bus.req_operand = opd; bus.req_nowrite = nw;
    bus.req_valid = 1'b1;
  endtask

  // One full instruction with an optional response stall, checked cycle by cycle.
  task automatic run_req(input logic [1:0] op, input logic [11:0] a, input logic [31:0] opd,
                         input logic nw, input int stall, input string tag);
    logic [31:0] e_data, e_set, e_clr;
    logic e_ill, e_en;
    int en0;
    int waits;
    model_req(op, a, opd, nw, 1'b1, e_data, e_ill, e_en, e_set, e_clr);
    drive_req(op, a, opd, nw);
    #1;
    waits = 0;
    while (!bus.req_ready && waits < 20) begin
      @(posedge clk); #1; waits++;
    end
    n_checks++;
    if (!bus.req_ready) begin
      n_fail++; $display("FAIL %s ready timeout: got 0 want 1", tag);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    en0 = en_count;
    n_checks++;
    if (bus.csr_en !== e_en) begin
      n_fail++; $display("FAIL %s en: got %0b want %0b", tag, bus.csr_en, e_en);
    end
    if (e_en) begin
      n_checks++;
      if ({bus.csr_addr, bus.csr_set, bus.csr_clear} !== {a, e_set, e_clr}) begin
        n_fail++;
        $display("FAIL %s bus: got addr=%h set=%h clr=%h want addr=%h set=%h clr=%h", tag,
                 bus.csr_addr, bus.csr_set, bus.csr_clear, a, e_set, e_clr);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i <= stall; i++) begin
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_illegal} !== {1'b1, e_data, e_ill}) begin
        n_fail++;
        $display("FAIL %s rsp[%0d]: got v=%0b d=%h ill=%0b want v=1 d=%h ill=%0b", tag, i,
                 bus.rsp_valid, bus.rsp_data, bus.rsp_illegal, e_data, e_ill);
      end
      if (i == stall) bus.rsp_ready = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || en_count != en0 + (e_en ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s done: got v=%0b pulses=%0d want v=0 pulses=%0d", tag, bus.rsp_valid,
               en_count - en0, e_en ? 1 : 0);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_illegal, bus.csr_en, bus.csr_addr, bus.csr_set,
         bus.csr_clear} !== '0) begin
      n_fail++; $display("FAIL reset outputs: got nonzero want all 0");
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset ready: got %0b want 1", bus.req_ready);
    end
  endtask

  task automatic test_rw;
    preload(2'd0, 32'h0000_00F0);
    run_req(2'b01, 12'h340, 32'h1234_5678, 1'b0, 0, "rw");
    n_checks++;
    if (fab_mem[0] !== 32'h1234_5678) begin
      n_fail++; $display("FAIL rw value: got %h want 12345678", fab_mem[0]);
    end
    run_req(2'b10, 12'h340, 32'h0, 1'b1, 0, "rw_readback");
  endtask

  task automatic test_rs_rc;
    preload(2'd0, 32'h0000_00F0);
    run_req(2'b10, 12'h340, 32'h0000_000F, 1'b0, 0, "rs");
    run_req(2'b11, 12'h340, 32'h0000_00F0, 1'b0, 0, "rc");
    n_checks++;
    if (fab_mem[0] !== 32'h0000_000F) begin
      n_fail++; $display("FAIL rs_rc value: got %h want 0000000f", fab_mem[0]);
    end
  endtask

  task automatic test_nowrite;
    run_req(2'b10, 12'h340, 32'hFFFF_FFFF, 1'b1, 0, "rs_nowrite");
    run_req(2'b11, 12'h340, 32'hFFFF_FFFF, 1'b1, 0, "rc_nowrite");
    n_checks++;
    if (fab_mem[0] !== 32'h0000_000F) begin
      n_fail++; $display("FAIL nowrite value: got %h want 0000000f", fab_mem[0]);
    end
  endtask

  task automatic test_illegal;
    run_req(2'b01, 12'h7C0, 32'hA5A5_A5A5, 1'b0, 0, "no_ack");
    run_req(2'b01, 12'hC00, 32'h1111_1111, 1'b0, 0, "ro_write");
    run_req(2'b10, 12'hC00, 32'h0, 1'b1, 0, "ro_read");
    run_req(2'b00, 12'h340, 32'h2222_2222, 1'b0, 1, "reserved_op");
  endtask

  task automatic test_back_to_back;
    logic [31:0] da, db, s, c;
    logic il, en;
    int en0;
    model_req(2'b01, 12'h340, 32'hCAFE_0001, 1'b0, 1'b1, da, il, en, s, c);
    model_req(2'b10, 12'h341, 32'h0000_0300, 1'b0, 1'b1, db, il, en, s, c);
    bus.rsp_ready = 1'b1;
    en0 = en_count;
    drive_req(2'b01, 12'h340, 32'hCAFE_0001, 1'b0);
    @(posedge clk); #1;
    drive_req(2'b10, 12'h341, 32'h0000_0300, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.req_ready} !== {1'b1, da, 1'b1}) begin
      n_fail++; $display("FAIL b2b rsp_a: got v=%0b d=%h rdy=%0b want v=1 d=%h rdy=1",
                         bus.rsp_valid, bus.rsp_data, bus.req_ready, da);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_checks++;
    if ({bus.csr_en, bus.csr_addr, bus.rsp_valid} !== {1'b1, 12'h341, 1'b0}) begin
      n_fail++; $display("FAIL b2b access_b: got en=%0b a=%h v=%0b want en=1 a=341 v=0",
                         bus.csr_en, bus.csr_addr, bus.rsp_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, db}) begin
      n_fail++; $display("FAIL b2b rsp_b: got v=%0b d=%h want v=1 d=%h", bus.rsp_valid,
                         bus.rsp_data, db);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    n_checks++;
    if (en_count - en0 != 2 || last_en_cyc - prev_en_cyc != 2 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b spacing: got pulses=%0d gap=%0d want pulses=2 gap=2",
                         en_count - en0, last_en_cyc - prev_en_cyc);
    end
  endtask

  task automatic test_stall;
    run_req(2'b11, 12'h341, 32'h0000_0100, 1'b0, 3, "stall");
  endtask

  task automatic test_kill;
    logic [31:0] d, s, c;
    logic il, en;
    int en0;
    en0 = en_count;
    drive_req(2'b01, 12'h341, 32'h7777_7777, 1'b0);
    bus.kill = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL kill_idle ready: got %0b want 0", bus.req_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (en_count != en0 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL kill_idle effect: got pulses=%0d v=%0b want 0 0",
                         en_count - en0, bus.rsp_valid);
    end
    bus.kill = 1'b0;
    // Kill during ACCESS: no write, no response.
    model_req(2'b01, 12'h341, 32'h7777_7777, 1'b0, 1'b0, d, il, en, s, c);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.kill = 1'b1;
    #1;
    en0 = en_count;
    n_checks++;
    if (bus.csr_en !== 1'b0) begin
      n_fail++; $display("FAIL kill_access en: got %0b want 0", bus.csr_en);
    end
    @(posedge clk); #1;
    bus.kill = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (en_count != en0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL kill_access after: got pulses=%0d v=%0b rdy=%0b want 0 0 1",
                         en_count - en0, bus.rsp_valid, bus.req_ready);
    end
    // Kill during RESP: the write already happened, response is dropped.
    model_req(2'b10, 12'h341, 32'h0000_0003, 1'b0, 1'b1, d, il, en, s, c);
    drive_req(2'b10, 12'h341, 32'h0000_0003, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, d}) begin
      n_fail++; $display("FAIL kill_resp pre: got v=%0b d=%h want v=1 d=%h", bus.rsp_valid,
                         bus.rsp_data, d);
    end
    bus.kill = 1'b1;
    #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL kill_resp drop: got %0b want 0", bus.rsp_valid);
    end
    @(posedge clk); #1;
    bus.kill = 1'b0;
    #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL kill_resp idle: got v=%0b rdy=%0b want 0 1", bus.rsp_valid,
                         bus.req_ready);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d, s, c;
    logic il, en;
    model_req(2'b10, 12'h305, 32'h0000_0011, 1'b0, 1'b1, d, il, en, s, c);
    drive_req(2'b10, 12'h305, 32'h0000_0011, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_data} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL reset_resp: got v=%0b d=%h want v=0 d=0", bus.rsp_valid,
                         bus.rsp_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Reset during ACCESS: the enable drops at once and the write is lost.
    model_req(2'b01, 12'h305, 32'hBAD0_BAD0, 1'b0, 1'b0, d, il, en, s, c);
    drive_req(2'b01, 12'h305, 32'hBAD0_BAD0, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.csr_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_access en: got %0b want 0", bus.csr_en);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_random;
    logic [11:0] addrs [6];
    addrs = '{12'h340, 12'h341, 12'h305, 12'hC00, 12'h7C0, 12'hF14};
    for (int i = 0; i < 40; i++) begin
      run_req(2'($urandom_range(0, 3)), addrs[$urandom_range(0, 5)], $urandom,
              1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)), "random");
    end
  endtask

  task automatic test_final_state;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (fab_mem[i] !== model_mem[i]) begin
        n_fail++; $display("FAIL final csr[%0d]: got %h want %h", i, fab_mem[i], model_mem[i]);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = 12'h0; bus.req_operand = 32'h0;
    bus.req_nowrite = 1'b0; bus.kill = 1'b0; bus.rsp_ready = 1'b0;
    test_reset();
    preload(2'd0, 32'h0000_00F0);
    preload(2'd1, 32'h0000_0000);
    preload(2'd2, 32'h0000_0100);
    preload(2'd3, 32'h0000_0055);
    test_rw();
    test_rs_rc();
    test_nowrite();
    test_illegal();
    test_back_to_back();
    test_stall();
    test_kill();
    test_reset_mid();
    test_random();
    test_final_state();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000ns");
    $fatal(1);
  end

endmodule
